// File: rtl/msk_cst_loader.sv
// Serial loader packing BEATS public count-bit beats into one registered d-share sharing.
// Define MSKCST_RANDOMIZE_EN (with d>1) to re-randomise shares from the rnd input on each accept.
module msk_cst_loader #(
  parameter int unsigned d     = 1,
  parameter int unsigned count = 1,
  parameter int unsigned BEATS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [count-1:0]             cst,
`ifdef MSKCST_RANDOMIZE_EN
  input  logic [((d > 1) ? (d-1)*count : 1)-1:0] rnd,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [count*BEATS*d-1:0]     out
);

  localparam int unsigned GW = count * d;
  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {FILL, FULL} state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CW-1:0]            r_beat_cnt;
  logic [count*BEATS*d-1:0] r_out;
  logic [GW-1:0]            w_group;
  logic                     w_accept;
  logic                     w_last;

  assign w_accept = in_valid & in_ready & ~flush;
  assign w_last   = (r_beat_cnt == CW'(BEATS - 1));

  // Share encoding of one beat: data share in the top bit of every d-bit group.
`ifdef MSKCST_RANDOMIZE_EN
  if (d > 1) begin : g_rand
    for (genvar i = 0; i < count; i++) begin : g_bit
      logic [d-2:0] w_sh;
      assign w_sh = rnd[i*(d-1) +: d-1];
      assign w_group[i*d +: d] = {cst[i] ^ (^w_sh), w_sh};
    end
  end else begin : g_single
    assign w_group = cst;
  end
`else
  if (d > 1) begin : g_zero
    for (genvar i = 0; i < count; i++) begin : g_bit
      assign w_group[i*d +: d] = {cst[i], {(d-1){1'b0}}};
    end
  end else begin : g_single
    assign w_group = cst;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handover and the first beat of the next word can occur in the same FULL cycle.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = FILL;
    end else if (w_accept && w_last) begin
      w_next_state = FULL;
    end else if (r_state == FULL && out_ready) begin
      w_next_state = FILL;
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (r_state == FULL) begin
      in_ready  = out_ready;
      out_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_out      <= '0;
    end else if (flush) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_out[32'(r_beat_cnt) * GW +: GW] <= w_group;
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + CW'(1);
    end
  end

  assign out = r_out;

endmodule
